irs_addr_sequencer: RTL
=======================

Name: irs_addr_sequencer

Overview:
- Parametrised successor to the IRS3B read-address control.
- Serially loads an arbitrary start address into the IRS read-address shift register over DO_DIR/DO_SIN/DO_SCLK.
- Then issues a programmable burst of N address increments, strobing once per increment when the addressed sample is settled.
- Sits between the readout FSM, which issues commands and latches data on each strobe, and the ASIC pins. Gated by the digitiser clock enable.

Parameters:
- ADDR_BITS, 9: width of the IRS read address (channel and sample bits).
- LSB_FIRST, 1: 1 shifts addr[0] first; 0 shifts addr[ADDR_BITS-1] first.
- CNT_BITS, 8: width of the timing counter. All timing parameters must be below 2^CNT_BITS.
- DIR_SETUP, 10: enabled cycles minus 1 that DIR is stable before the first SCLK activity of a phase.
- SCLK_LOW, 10: enabled cycles minus 1 of each shift low phase (SIN valid).
- SCLK_HIGH, 10: enabled cycles minus 1 of each shift high phase.
- SHIFT_HOLD, 10: enabled cycles minus 1 after the last shift, with DIR held high.
- INCR_HIGH, 1: enabled cycles minus 1 that SCLK is high per increment.
- INCR_SETTLE, 1: enabled cycles minus 1 after SCLK falls before sample_strobe_o.
- NINC_BITS, 10: width of the increment count.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- clk_en_i  in  1  clock enable. All state, counters and registered outputs advance only when it is 1.
- start_i  in  1  command request, sampled in IDLE when clk_en_i=1
- load_i  in  1  1: serial-load start_addr_i before the increments; 0: increment from the current address
- start_addr_i  in  ADDR_BITS  start address, captured at command accept
- n_incr_i  in  NINC_BITS  number of increments, captured at command accept; 0 is legal
- abort_i  in  1  abandons the current command
- busy_o  out  1  high from accept until the cycle after done_o
- done_o  out  1  one enabled-cycle pulse at command completion (not asserted on abort)
- sample_strobe_o  out  1  one enabled-cycle pulse per increment when data is settled
- cur_addr_o  out  ADDR_BITS  address the ASIC currently points at
- DO_DIR  out  1  1 = shift mode, 0 = increment mode / idle
- DO_SIN  out  1  serial address bit
- DO_SCLK  out  1  shift/increment clock

Behaviour:
- Reset: all outputs are 0, cur_addr_o is 0, state is IDLE, counters are 0.
- All outputs are registered and depend on the next state (Moore), so there are no glitches.
- States:
  - IDLE: when start_i=1, capture the command and set busy_o=1. If load_i=1, go to LOAD_SETUP. Else if n_incr_i>0, go to INCR_SETUP. Else go to DONE.
  - LOAD_SETUP: DIR=1, SCLK=0, for DIR_SETUP+1 cycles, then go to SHIFT_LOW. The bit index is 0.
  - SHIFT_LOW: DIR=1, SCLK=0, SIN = the selected address bit, for SCLK_LOW+1 cycles, then go to SHIFT_HIGH.
  - SHIFT_HIGH: SCLK=1, SIN held, for SCLK_HIGH+1 cycles. Then the bit index increments. If the index reaches ADDR_BITS, go to LOAD_HOLD; else go to SHIFT_LOW.
  - LOAD_HOLD: DIR=1, SCLK=0, for SHIFT_HOLD+1 cycles. On exit, cur_addr_o <= start_addr. If n_incr>0, go to INCR_SETUP; else go to DONE.
  - INCR_SETUP: DIR=0, SCLK=0, for DIR_SETUP+1 cycles, then go to INCR_HI.
  - INCR_HI: DIR=0, SCLK=1, for INCR_HIGH+1 cycles. On exit, cur_addr_o <= cur_addr_o+1, wrapping modulo 2^ADDR_BITS, and go to INCR_SETTLE.
  - INCR_SETTLE: SCLK=0, for INCR_SETTLE+1 cycles. sample_strobe_o=1 on the last cycle and the remaining count decrements. If the remaining count is 0, go to DONE; else go to INCR_HI.
  - DONE: done_o=1 for one cycle, then go to IDLE. busy_o falls on entry to IDLE.
- Bit selection: with LSB_FIRST, bit i of the load sequence is addr[i]; otherwise it is addr[ADDR_BITS-1-i].
- Timing counter: resets to 0 on every state change and holds when clk_en_i=0.
- DIR ordering: DIR never changes in the same cycle that SCLK rises.
- start_i while busy is ignored, with no queueing.
- abort_i (enabled cycle, any non-IDLE state): next state is IDLE with DIR/SCLK/SIN=0. No done_o or strobe is issued. cur_addr_o keeps its last committed value, so a load aborted before LOAD_HOLD exit does not update it. abort_i has priority over start_i.
- A command with load_i=0 and n_incr=0 completes in 2 enabled cycles (accept, DONE).
- Asynchronous reset mid-operation forces the reset values immediately.

Decomposition:
- Package irs_seq_pkg holds:
  - the state encoding localparams;
  - the default timing constants, shared with the digitiser control.
- Optional sub-module irs_phase_timer: loadable down/up counter with a terminal-count flag and enable. It is the natural single sub-block; everything else stays in one FSM.

Test Plan:
- Defaults, load_i=1, start_addr=0x0A5, n=0, clk_en=1 → 9 SCLK rises with SIN = 1,0,1,0,0,1,0,1,0. The first rise comes 22 cycles after accept. done_o comes at cycle 221. cur_addr_o=0x0A5, busy_o low on cycle 222.
- load_i=1, addr=0x1FE, n=3 → three strobes with cur_addr_o = 0x1FF, 0x000, 0x001 (wrap). DIR low for ≥11 cycles before the first increment rise.
- LSB_FIRST=0, addr=0x100 → SIN sequence 1,0,0,0,0,0,0,0,0.
- load_i=0 from cur_addr=0x005, n=1 → DIR stays 0, one SCLK pulse, strobe with cur_addr_o=0x006, then done. With n=0 → done 1 cycle after accept.
- clk_en_i at 1-in-4 duty, first scenario → identical pin sequence, all durations ×4. start_i pulsed while busy is ignored.
- abort_i during the 5th shift-high → IDLE next enabled cycle, pins low, cur_addr_o unchanged, no done_o. rst_n_i asserted mid-burst → all outputs 0 asynchronously.

Source files
------------

// File: rtl/irs_seq_pkg.sv
// Shared types and default timing for the IRS read-address sequencer.
package irs_seq_pkg;

  // Default geometry and timing, also used by the digitiser control.
  localparam int unsigned IRS_ADDR_BITS   = 9;
  localparam bit          IRS_LSB_FIRST   = 1'b1;
  localparam int unsigned IRS_CNT_BITS    = 8;
  localparam int unsigned IRS_DIR_SETUP   = 10;
  localparam int unsigned IRS_SCLK_LOW    = 10;
  localparam int unsigned IRS_SCLK_HIGH   = 10;
  localparam int unsigned IRS_SHIFT_HOLD  = 10;
  localparam int unsigned IRS_INCR_HIGH   = 1;
  localparam int unsigned IRS_INCR_SETTLE = 1;
  localparam int unsigned IRS_NINC_BITS   = 10;

  // State encoding.
  localparam int unsigned STATE_BITS = 4;
  localparam logic [STATE_BITS-1:0] ST_IDLE        = 4'd0;
  localparam logic [STATE_BITS-1:0] ST_LOAD_SETUP  = 4'd1;
  localparam logic [STATE_BITS-1:0] ST_SHIFT_LOW   = 4'd2;
  localparam logic [STATE_BITS-1:0] ST_SHIFT_HIGH  = 4'd3;
  localparam logic [STATE_BITS-1:0] ST_LOAD_HOLD   = 4'd4;
  localparam logic [STATE_BITS-1:0] ST_INCR_SETUP  = 4'd5;
  localparam logic [STATE_BITS-1:0] ST_INCR_HI     = 4'd6;
  localparam logic [STATE_BITS-1:0] ST_INCR_SETTLE = 4'd7;
  localparam logic [STATE_BITS-1:0] ST_DONE        = 4'd8;

  typedef enum logic [STATE_BITS-1:0] {
    S_IDLE        = ST_IDLE,
    S_LOAD_SETUP  = ST_LOAD_SETUP,
    S_SHIFT_LOW   = ST_SHIFT_LOW,
    S_SHIFT_HIGH  = ST_SHIFT_HIGH,
    S_LOAD_HOLD   = ST_LOAD_HOLD,
    S_INCR_SETUP  = ST_INCR_SETUP,
    S_INCR_HI     = ST_INCR_HI,
    S_INCR_SETTLE = ST_INCR_SETTLE,
    S_DONE        = ST_DONE
  } state_t;

endpackage

// File: rtl/irs_addr_sequencer_timer.sv
// Phase timer: up-counter restarted on every phase change, flags the last cycle of a phase.
module irs_phase_timer #(
  parameter int unsigned CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                restart,
  input  logic [CNT_BITS-1:0] limit,
  output logic                tc_c,
  output logic [CNT_BITS-1:0] count_next_c
);

  logic [CNT_BITS-1:0] count;

  // Terminal count: current phase has run limit+1 enabled cycles.
  always_comb tc_c = (count == limit);

  // Value the counter takes at the next enabled edge.
  always_comb count_next_c = restart ? '0 : count + CNT_BITS'(1);

  // Counter register, frozen while the clock enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/irs_addr_sequencer.sv
// IRS read-address sequencer: serial address load followed by a burst of increments.
module irs_addr_sequencer
  import irs_seq_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = IRS_ADDR_BITS,
  parameter bit          LSB_FIRST   = IRS_LSB_FIRST,
  parameter int unsigned CNT_BITS    = IRS_CNT_BITS,
  parameter int unsigned DIR_SETUP   = IRS_DIR_SETUP,
  parameter int unsigned SCLK_LOW    = IRS_SCLK_LOW,
  parameter int unsigned SCLK_HIGH   = IRS_SCLK_HIGH,
  parameter int unsigned SHIFT_HOLD  = IRS_SHIFT_HOLD,
  parameter int unsigned INCR_HIGH   = IRS_INCR_HIGH,
  parameter int unsigned INCR_SETTLE = IRS_INCR_SETTLE,
  parameter int unsigned NINC_BITS   = IRS_NINC_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clk_en_i,
  input  logic                 start_i,
  input  logic                 load_i,
  input  logic [ADDR_BITS-1:0] start_addr_i,
  input  logic [NINC_BITS-1:0] n_incr_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sample_strobe_o,
  output logic [ADDR_BITS-1:0] cur_addr_o,
  output logic                 DO_DIR,
  output logic                 DO_SIN,
  output logic                 DO_SCLK
);

  localparam int unsigned IDX_BITS = $clog2(ADDR_BITS + 1);

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] addr, addr_nxt;
  logic [NINC_BITS-1:0] rem, rem_nxt;
  logic [IDX_BITS-1:0]  idx, idx_nxt;
  logic [ADDR_BITS-1:0] cur_nxt;

  logic                 busy_nxt, done_nxt, strobe_nxt;
  logic                 dir_nxt, sin_nxt, sclk_nxt;

  logic [CNT_BITS-1:0]  limit;
  logic                 restart;
  logic                 tc;
  logic [CNT_BITS-1:0]  cnt_next;

  // Address bit shifted at position i of the load sequence.
  function automatic logic sel_bit(input logic [ADDR_BITS-1:0] a,
                                   input logic [IDX_BITS-1:0]  i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < ADDR_BITS; k++) begin
      if (i == IDX_BITS'(k)) begin
        b = LSB_FIRST ? a[k] : a[ADDR_BITS-1-k];
      end
    end
    return b;
  endfunction

  // Phase length (minus one) of the current state.
  always_comb begin
    limit = '0;
    unique case (state)
      S_LOAD_SETUP,
      S_INCR_SETUP:  limit = CNT_BITS'(DIR_SETUP);
      S_SHIFT_LOW:   limit = CNT_BITS'(SCLK_LOW);
      S_SHIFT_HIGH:  limit = CNT_BITS'(SCLK_HIGH);
      S_LOAD_HOLD:   limit = CNT_BITS'(SHIFT_HOLD);
      S_INCR_HI:     limit = CNT_BITS'(INCR_HIGH);
      S_INCR_SETTLE: limit = CNT_BITS'(INCR_SETTLE);
      default:       limit = '0;
    endcase
  end

  // Timer restarts on every state change and idles at zero.
  always_comb restart = (state_nxt != state) || (state == S_IDLE);

  irs_phase_timer #(
    .CNT_BITS (CNT_BITS)
  ) u_timer (
    .clk          (clk_i),
    .rst_n        (rst_n_i),
    .en           (clk_en_i),
    .restart      (restart),
    .limit        (limit),
    .tc_c         (tc),
    .count_next_c (cnt_next)
  );

  // Next-state and command bookkeeping.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rem_nxt   = rem;
    idx_nxt   = idx;
    cur_nxt   = cur_addr_o;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          addr_nxt = start_addr_i;
          rem_nxt  = n_incr_i;
          idx_nxt  = '0;
          if (load_i)                state_nxt = S_LOAD_SETUP;
          else if (n_incr_i != '0)   state_nxt = S_INCR_SETUP;
          else                       state_nxt = S_DONE;
        end
      end
      S_LOAD_SETUP: if (tc) state_nxt = S_SHIFT_LOW;
      S_SHIFT_LOW:  if (tc) state_nxt = S_SHIFT_HIGH;
      S_SHIFT_HIGH: begin
        if (tc) begin
          idx_nxt = idx + IDX_BITS'(1);
          if (idx == IDX_BITS'(ADDR_BITS - 1)) state_nxt = S_LOAD_HOLD;
          else                                 state_nxt = S_SHIFT_LOW;
        end
      end
      S_LOAD_HOLD: begin
        if (tc) begin
          cur_nxt   = addr;
          state_nxt = (rem != '0) ? S_INCR_SETUP : S_DONE;
        end
      end
      S_INCR_SETUP: if (tc) state_nxt = S_INCR_HI;
      S_INCR_HI: begin
        if (tc) begin
          cur_nxt   = cur_addr_o + ADDR_BITS'(1);
          state_nxt = S_INCR_SETTLE;
        end
      end
      S_INCR_SETTLE: begin
        if (tc) begin
          rem_nxt   = rem - NINC_BITS'(1);
          state_nxt = (rem == NINC_BITS'(1)) ? S_DONE : S_INCR_HI;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort drops everything; the committed address is left untouched.
    if (abort_i && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      cur_nxt   = cur_addr_o;
      rem_nxt   = rem;
      idx_nxt   = idx;
    end
  end

  // Moore outputs decoded from the next state, registered below.
  always_comb begin
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    strobe_nxt = 1'b0;
    dir_nxt    = 1'b0;
    sin_nxt    = 1'b0;
    sclk_nxt   = 1'b0;
    unique case (state_nxt)
      S_IDLE: ;
      S_LOAD_SETUP,
      S_LOAD_HOLD: begin
        busy_nxt = 1'b1;
        dir_nxt  = 1'b1;
      end
      S_SHIFT_LOW: begin
        busy_nxt = 1'b1;
        dir_nxt  = 1'b1;
        sin_nxt  = sel_bit(addr_nxt, idx_nxt);
      end
      S_SHIFT_HIGH: begin
        busy_nxt = 1'b1;
        dir_nxt  = 1'b1;
        sclk_nxt = 1'b1;
        sin_nxt  = sel_bit(addr_nxt, idx_nxt);
      end
      S_INCR_SETUP: busy_nxt = 1'b1;
      S_INCR_HI: begin
        busy_nxt = 1'b1;
        sclk_nxt = 1'b1;
      end
      S_INCR_SETTLE: begin
        busy_nxt   = 1'b1;
        strobe_nxt = (cnt_next == CNT_BITS'(INCR_SETTLE));
      end
      S_DONE: begin
        busy_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // State, bookkeeping and output registers, gated by the clock enable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= S_IDLE;
      addr            <= '0;
      rem             <= '0;
      idx             <= '0;
      cur_addr_o      <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      sample_strobe_o <= 1'b0;
      DO_DIR          <= 1'b0;
      DO_SIN          <= 1'b0;
      DO_SCLK         <= 1'b0;
    end else if (clk_en_i) begin
      state           <= state_nxt;
      addr            <= addr_nxt;
      rem             <= rem_nxt;
      idx             <= idx_nxt;
      cur_addr_o      <= cur_nxt;
      busy_o          <= busy_nxt;
      done_o          <= done_nxt;
      sample_strobe_o <= strobe_nxt;
      DO_DIR          <= dir_nxt;
      DO_SIN          <= sin_nxt;
      DO_SCLK         <= sclk_nxt;
    end
  end

endmodule
